port_flit_receiver: RTL

//  Downstream receiving end of one crossbar output link: captures {flit, we} from a router output

---
 rtl/port_flit_receiver.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/port_flit_receiver.sv
// Receiving end of one crossbar output link: per-VC flit FIFOs, per-VC packet framing check,
// one registered credit pulse per popped flit, and sticky link protocol error flags.
module port_flit_receiver #(
    parameter int V    = 4,
    parameter int B    = 4,
    parameter int Fpay = 32,
    localparam int Fw  = 2 + V + Fpay,
    localparam int PW  = $clog2(B)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [Fw-1:0] flit_in,
    input  logic          flit_in_we,
    input  logic [V-1:0]  rd_vc,
    input  logic          rd_en,
    output logic [Fw-1:0] flit_out,
    output logic [V-1:0]  vc_not_empty,
    output logic [V-1:0]  vc_pkt_active,
    output logic [V-1:0]  credit_out,
    output logic          err_overflow,
    output logic          err_vc,
    output logic          err_framing,
    input  logic          err_clr
);

    localparam logic [PW:0]   FULL_CNT = (PW+1)'(B);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } frm_state_e;

    // True when exactly one bit of the vector is set.
    function automatic logic is_onehot(input logic [V-1:0] vec);
        return (vec != '0) && ((vec & (vec - {{(V-1){1'b0}}, 1'b1})) == '0);
    endfunction

    logic [Fw-1:0] mem_r     [V][B];
    logic [PW-1:0] wr_ptr_r  [V];
    logic [PW-1:0] rd_ptr_r  [V];
    logic [PW:0]   count_r   [V];
    frm_state_e    frm_state_r [V];
    frm_state_e    frm_state_nxt_s [V];

    logic [V-1:0]  wr_vc_s;
    logic          hdr_s;
    logic          tail_s;
    logic          wr_onehot_s;
    logic          rd_onehot_s;
    logic [V-1:0]  full_vec_s;
    logic [V-1:0]  frm_ok_vec_s;
    logic          wr_full_s;
    logic          wr_frm_ok_s;
    logic          wr_accept_s;
    logic [V-1:0]  wr_en_vec_s;
    logic [V-1:0]  pop_vec_s;
    logic          set_vc_s;
    logic          set_ovf_s;
    logic          set_frm_s;

    assign hdr_s       = flit_in[Fw-1];
    assign tail_s      = flit_in[Fw-2];
    assign wr_vc_s     = flit_in[Fw-3:Fpay];
    assign wr_onehot_s = is_onehot(wr_vc_s);
    assign rd_onehot_s = is_onehot(rd_vc);

    // Per-VC status flags and framing acceptance for the incoming flit.
    always_comb begin
        full_vec_s    = '0;
        frm_ok_vec_s  = '0;
        vc_not_empty  = '0;
        vc_pkt_active = '0;
        for (int v = 0; v < V; v++) begin
            full_vec_s[v]    = (count_r[v] == FULL_CNT);
            vc_not_empty[v]  = (count_r[v] != '0);
            vc_pkt_active[v] = (frm_state_r[v] == ST_ACTIVE);
            case (frm_state_r[v])
                ST_IDLE:   frm_ok_vec_s[v] = hdr_s;
                ST_ACTIVE: frm_ok_vec_s[v] = ~hdr_s;
                default:   frm_ok_vec_s[v] = 1'b0;
            endcase
        end
    end

    // Write/pop decisions; error priority is vc field, then overflow, then framing.
    always_comb begin
        wr_full_s   = |(wr_vc_s & full_vec_s);
        wr_frm_ok_s = |(wr_vc_s & frm_ok_vec_s);
        set_vc_s    = flit_in_we & ~wr_onehot_s;
        set_ovf_s   = flit_in_we & wr_onehot_s & wr_full_s;
        set_frm_s   = flit_in_we & wr_onehot_s & ~wr_full_s & ~wr_frm_ok_s;
        wr_accept_s = flit_in_we & wr_onehot_s & ~wr_full_s & wr_frm_ok_s;
        if (wr_accept_s) begin
            wr_en_vec_s = wr_vc_s;
        end else begin
            wr_en_vec_s = '0;
        end
        // Pop eligibility uses registered occupancy, so a write into an empty VC cannot be popped.
        if (rd_en && rd_onehot_s) begin
            pop_vec_s = rd_vc & vc_not_empty;
        end else begin
            pop_vec_s = '0;
        end
    end

    // Framing next-state: an accepted tail closes the packet, anything else accepted leaves it open.
    always_comb begin
        for (int v = 0; v < V; v++) begin
            frm_state_nxt_s[v] = frm_state_r[v];
            if (wr_en_vec_s[v]) begin
                case (frm_state_r[v])
                    ST_IDLE:   frm_state_nxt_s[v] = tail_s ? ST_IDLE : ST_ACTIVE;
                    ST_ACTIVE: frm_state_nxt_s[v] = tail_s ? ST_IDLE : ST_ACTIVE;
                    default:   frm_state_nxt_s[v] = ST_IDLE;
                endcase
            end else begin
                frm_state_nxt_s[v] = frm_state_r[v];
            end
        end
    end

    // Fall-through head of the selected VC; zero when that VC is empty or rd_vc is malformed.
    always_comb begin
        flit_out = '0;
        for (int v = 0; v < V; v++) begin
            flit_out = flit_out |
                       ((rd_onehot_s && rd_vc[v] && vc_not_empty[v]) ? mem_r[v][rd_ptr_r[v]] : '0);
        end
    end

    // Flit storage; contents are don't-care while the pointers say empty, so no reset.
    always_ff @(posedge clk) begin
        for (int v = 0; v < V; v++) begin
            if (wr_en_vec_s[v]) begin
                mem_r[v][wr_ptr_r[v]] <= flit_in;
            end
        end
    end

    // Pointers, occupancy, framing state, credits and sticky errors.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int v = 0; v < V; v++) begin
                wr_ptr_r[v]    <= '0;
                rd_ptr_r[v]    <= '0;
                count_r[v]     <= '0;
                frm_state_r[v] <= ST_IDLE;
            end
            credit_out   <= '0;
            err_overflow <= 1'b0;
            err_vc       <= 1'b0;
            err_framing  <= 1'b0;
        end else begin
            for (int v = 0; v < V; v++) begin
                if (wr_en_vec_s[v]) begin
                    wr_ptr_r[v] <= wr_ptr_r[v] + PTR_ONE;
                end
                if (pop_vec_s[v]) begin
                    rd_ptr_r[v] <= rd_ptr_r[v] + PTR_ONE;
                end
                count_r[v]     <= count_r[v] + (PW+1)'(wr_en_vec_s[v]) - (PW+1)'(pop_vec_s[v]);
                frm_state_r[v] <= frm_state_nxt_s[v];
            end
            credit_out   <= pop_vec_s;
            err_overflow <= set_ovf_s | (err_overflow & ~err_clr);
            err_vc       <= set_vc_s  | (err_vc & ~err_clr);
            err_framing  <= set_frm_s | (err_framing & ~err_clr);
        end
    end

endmodule
